// File: rtl/dkong3_video_pkg.sv
// rtl/dkong3_video_pkg.sv - shared video constants and background fetch state type
package dkong3_video_pkg;

  localparam int PIX_PER_TILE = 8;
  localparam int ROW_W        = 5;
  localparam int COL_W        = 5;
  localparam int LINE_W       = 3;
  localparam int LINE_PIX     = 384;

  // Sub-tile pixel phases: fetch starts mid-tile, shifter reloads on the last pixel.
  localparam int PHASE_FETCH  = PIX_PER_TILE / 2;
  localparam int PHASE_LOAD   = PIX_PER_TILE - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VADR  = 3'd1,
    ST_VWAIT = 3'd2,
    ST_CODE  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_LATCH = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/dkong3_bg_tile_if.sv
// rtl/dkong3_bg_tile_if.sv - tile map, tile ROM and colour PROM memory bus
interface dkong3_bg_tile_if;

  logic [9:0]  O_VRAM_A;
  logic [7:0]  I_VRAM_D;
  logic [11:0] O_ROM_A;
  logic [15:0] I_ROM_D;
  logic [7:0]  O_CPROM_A;
  logic [3:0]  I_CPROM_D;

  // Tile generator side: drives addresses, receives registered read data.
  modport master (
    output O_VRAM_A, O_ROM_A, O_CPROM_A,
    input  I_VRAM_D, I_ROM_D, I_CPROM_D
  );

  // Memory side: synchronous read, data one clock after the address.
  modport slave (
    input  O_VRAM_A, O_ROM_A, O_CPROM_A,
    output I_VRAM_D, I_ROM_D, I_CPROM_D
  );

endinterface

// File: rtl/dkong3_tile_shifter.sv
// rtl/dkong3_tile_shifter.sv - two-plane pixel shifter with palette and flip direction
module dkong3_tile_shifter (
  input  logic       I_CLK,
  input  logic       I_RST_n,
  input  logic       i_cen,
  input  logic       i_load,
  input  logic       i_flip,
  input  logic [7:0] i_plane0,
  input  logic [7:0] i_plane1,
  input  logic [3:0] i_pal,
  output logic [1:0] o_pix,
  output logic [3:0] o_pal
);

  logic [7:0] r_plane0;
  logic [7:0] r_plane1;
  logic [3:0] r_pal;
  logic       r_flip;

  // Load a whole tile at the column boundary, otherwise step one pixel per pixel enable.
  // The flip direction is frozen at load so a mid-tile flip change cannot scramble the tile.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      r_plane0 <= 8'd0;
      r_plane1 <= 8'd0;
      r_pal    <= 4'd0;
      r_flip   <= 1'b0;
    end else if (i_load) begin
      r_plane0 <= i_plane0;
      r_plane1 <= i_plane1;
      r_pal    <= i_pal;
      r_flip   <= i_flip;
    end else if (i_cen) begin
      if (r_flip) begin
        r_plane0 <= {1'b0, r_plane0[7:1]};
        r_plane1 <= {1'b0, r_plane1[7:1]};
      end else begin
        r_plane0 <= {r_plane0[6:0], 1'b0};
        r_plane1 <= {r_plane1[6:0], 1'b0};
      end
    end
  end

  assign o_pix = r_flip ? {r_plane1[0], r_plane0[0]} : {r_plane1[7], r_plane0[7]};
  assign o_pal = r_pal;

endmodule

// File: rtl/dkong3_bg_tile.sv
// rtl/dkong3_bg_tile.sv - background tile fetch one tile ahead of the beam and pixel output
module dkong3_bg_tile #(
  parameter int PREFETCH = 8,
  parameter int LINE_PIX = dkong3_video_pkg::LINE_PIX
) (
  input  logic             I_CLK,
  input  logic             I_RST_n,
  input  logic             I_PIX_CEN,
  input  logic [9:0]       I_H,
  input  logic [7:0]       I_VF,
  input  logic             I_CBLANKn,
  input  logic             I_HFLIP,
  input  logic             I_BANK,
  dkong3_bg_tile_if.master mem,
  output logic [5:0]       O_COL
);

  import dkong3_video_pkg::*;

  localparam logic [9:0] C_PREFETCH = 10'(PREFETCH);
  localparam logic [9:0] C_LINE_PIX = 10'(LINE_PIX);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [9:0]       w_sum;
  logic [9:0]       w_nx;
  logic [COL_W-1:0] w_col;
  logic             w_start;
  logic             w_load;
  logic             w_cap_req;
  logic             w_cap_code;
  logic             w_cap_tile;

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic              r_bank;

  logic [9:0]  r_vram_a;
  logic [11:0] r_rom_a;
  logic [7:0]  r_cprom_a;

  logic [7:0] r_hold_p0;
  logic [7:0] r_hold_p1;
  logic [3:0] r_hold_pal;

  logic [1:0] w_pix;
  logic [3:0] w_pal;
  logic [5:0] r_col_out;

  logic w_unused;

  // Look-ahead column wraps at the end of the line so column 0 is fetched in H blank.
  assign w_sum   = {1'b0, I_H[9:1]} + C_PREFETCH;
  assign w_nx    = (w_sum >= C_LINE_PIX) ? (w_sum - C_LINE_PIX) : w_sum;
  assign w_col   = w_nx[7:3] ^ {COL_W{I_HFLIP}};
  assign w_start = I_PIX_CEN && (I_H[3:1] == 3'(PHASE_FETCH));
  assign w_load  = I_PIX_CEN && (I_H[3:1] == 3'(PHASE_LOAD));

  // Fetch state register.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch sequencing runs on every clock; a start outside IDLE is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_req   = 1'b0;
    w_cap_code  = 1'b0;
    w_cap_tile  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_VADR;
      ST_VADR:  begin
                  w_cap_req   = 1'b1;
                  w_state_nxt = ST_VWAIT;
                end
      ST_VWAIT: w_state_nxt = ST_CODE;
      ST_CODE:  begin
                  w_cap_code  = 1'b1;
                  w_state_nxt = ST_RWAIT;
                end
      ST_RWAIT: w_state_nxt = ST_LATCH;
      ST_LATCH: begin
                  w_cap_tile  = 1'b1;
                  w_state_nxt = ST_IDLE;
                end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Request, address and holding registers; addresses hold between fetches.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_line     <= '0;
      r_bank     <= 1'b0;
      r_vram_a   <= '0;
      r_rom_a    <= '0;
      r_cprom_a  <= '0;
      r_hold_p0  <= '0;
      r_hold_p1  <= '0;
      r_hold_pal <= '0;
    end else begin
      if (w_cap_req) begin
        r_row    <= I_VF[7:3];
        r_col    <= w_col;
        r_line   <= I_VF[2:0];
        r_bank   <= I_BANK;
        r_vram_a <= {I_VF[7:3], w_col};
      end
      if (w_cap_code) begin
        r_rom_a   <= {r_bank, mem.I_VRAM_D, r_line};
        r_cprom_a <= {r_row[4:2], r_col};
      end
      if (w_cap_tile) begin
        r_hold_p0  <= mem.I_ROM_D[7:0];
        r_hold_p1  <= mem.I_ROM_D[15:8];
        r_hold_pal <= mem.I_CPROM_D;
      end
    end
  end

  assign mem.O_VRAM_A  = r_vram_a;
  assign mem.O_ROM_A   = r_rom_a;
  assign mem.O_CPROM_A = r_cprom_a;

  dkong3_tile_shifter u_shifter (
    .I_CLK    (I_CLK),
    .I_RST_n  (I_RST_n),
    .i_cen    (I_PIX_CEN),
    .i_load   (w_load),
    .i_flip   (I_HFLIP),
    .i_plane0 (r_hold_p0),
    .i_plane1 (r_hold_p1),
    .i_pal    (r_hold_pal),
    .o_pix    (w_pix),
    .o_pal    (w_pal)
  );

  // Output pixel, blanked with the same pixel enable that presents it.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      r_col_out <= 6'd0;
    end else if (I_PIX_CEN) begin
      r_col_out <= I_CBLANKn ? {w_pal, w_pix} : 6'd0;
    end
  end

  assign O_COL = r_col_out;

  assign w_unused = ^{I_H[0], w_nx[9:8], w_nx[2:0], r_row[1:0]};

endmodule

// File: tb/tb_dkong3_bg_tile.sv
// tb/tb_dkong3_bg_tile.sv - randomized self-checking bench with a pixel-timeline model
module tb_dkong3_bg_tile;
  import dkong3_video_pkg::*;

  localparam int PF    = 8;
  localparam int LP    = 384;
  localparam int NSTEP = 4096;

  logic       I_CLK = 1'b0;
  logic       I_RST_n = 1'b0;
  logic       I_PIX_CEN = 1'b0;
  logic [9:0] I_H = 10'd0;
  logic [7:0] I_VF = 8'd0;
  logic       I_CBLANKn = 1'b1;
  logic       I_HFLIP = 1'b0;
  logic       I_BANK = 1'b0;
  logic [5:0] O_COL;

  dkong3_bg_tile_if mem ();

  dkong3_bg_tile #(.PREFETCH(PF), .LINE_PIX(LP)) dut (
    .I_CLK     (I_CLK),
    .I_RST_n   (I_RST_n),
    .I_PIX_CEN (I_PIX_CEN),
    .I_H       (I_H),
    .I_VF      (I_VF),
    .I_CBLANKn (I_CBLANKn),
    .I_HFLIP   (I_HFLIP),
    .I_BANK    (I_BANK),
    .mem       (mem),
    .O_COL     (O_COL)
  );

  always #20 I_CLK = ~I_CLK;

  // External synchronous memories.
  logic [7:0]  vram  [1024];
  logic [15:0] rom   [4096];
  logic [3:0]  cprom [256];

  always @(posedge I_CLK) begin
    mem.I_VRAM_D  <= vram[mem.O_VRAM_A];
    mem.I_ROM_D   <= rom[mem.O_ROM_A];
    mem.I_CPROM_D <= cprom[mem.O_CPROM_A];
  end

  // Per-pixel record of what the bench presented.
  int         xs    [NSTEP];
  logic [7:0] vfs   [NSTEP];
  bit         flips [NSTEP];
  bit         banks [NSTEP];
  bit         vis   [NSTEP];
  logic [5:0]  obs_col  [NSTEP];
  logic [9:0]  obs_vram [NSTEP];
  logic [11:0] obs_rom  [NSTEP];

  int step_cnt = 0;
  int cur_step = 0;
  int rel = 0;
  int errors = 0;
  int checks = 0;
  bit run_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Map column seen by the fetch started at step s.
  function automatic logic [4:0] m_col(input int s);
    int nx;
    logic [4:0] c;
    nx = (xs[s] + PF) % LP;
    c = 5'((nx / 8) % 32);
    if (flips[s]) c = ~c;
    return c;
  endfunction

  function automatic logic [11:0] m_rom_a(input int s);
    logic [4:0] r;
    r = vfs[s][7:3];
    return {banks[s], vram[{r, m_col(s)}], vfs[s][2:0]};
  endfunction

  // Pixel n shows pixel j of the tile fetched 4+j pixels earlier, in the order
  // chosen at the load one pixel before the tile starts.
  function automatic logic [5:0] m_pix(input int n);
    int j, p, l, i;
    logic [4:0]  r, c;
    logic [15:0] pl;
    logic [3:0]  pal;
    j = xs[n] % 8;
    p = n - j - 4;
    l = n - j - 1;
    if (!vis[n] || p < rel) return 6'd0;
    r   = vfs[p][7:3];
    c   = m_col(p);
    pl  = rom[m_rom_a(p)];
    pal = cprom[{r[4:2], c}];
    i   = flips[l] ? j : 7 - j;
    return {pal, pl[8 + i], pl[i]};
  endfunction

  task automatic pix_step(input int x, input bit bl_n);
    @(negedge I_CLK);
    if (step_cnt >= NSTEP) begin
      $display("FAIL step_budget: got %0d expected below %0d", step_cnt, NSTEP);
      $fatal(1);
    end
    I_H       = 10'(x << 1);
    I_CBLANKn = bl_n;
    I_PIX_CEN = 1'b1;
    xs[step_cnt]    = x;
    vfs[step_cnt]   = I_VF;
    flips[step_cnt] = I_HFLIP;
    banks[step_cnt] = I_BANK;
    vis[step_cnt]   = bl_n;
    cur_step = step_cnt;
    step_cnt++;
    @(negedge I_CLK);
    I_PIX_CEN = 1'b0;
    repeat (2) @(negedge I_CLK);
  endtask

  // Compare process: pixel one clock after its enable, addresses after each fetch phase.
  bit cen_q = 1'b0;
  int k = 0;
  int cs = 0;
  always @(posedge I_CLK) cen_q <= I_PIX_CEN;

  always @(negedge I_CLK) begin
    if (run_active) begin
      if (cen_q) begin
        k  = 1;
        cs = cur_step;
      end else begin
        k++;
      end
      if (k == 1) begin
        obs_col[cs] = O_COL;
        chk($sformatf("pix s%0d x%0d", cs, xs[cs]), 32'(O_COL), 32'(m_pix(cs)));
      end
      if ((xs[cs] % 8) == 4 && cs >= rel) begin
        if (k == 2) begin
          obs_vram[cs] = mem.O_VRAM_A;
          chk($sformatf("vram_a s%0d", cs), 32'(mem.O_VRAM_A), 32'({vfs[cs][7:3], m_col(cs)}));
        end
        if (k == 4) begin
          obs_rom[cs] = mem.O_ROM_A;
          chk($sformatf("rom_a s%0d", cs), 32'(mem.O_ROM_A), 32'(m_rom_a(cs)));
          chk($sformatf("cprom_a s%0d", cs), 32'(mem.O_CPROM_A), 32'({vfs[cs][7:5], m_col(cs)}));
        end
      end
    end
  end

  int base1, base2;
  logic [5:0] lit_n [8];
  logic [5:0] lit_f [8];

  initial begin
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) cprom[i] = 4'($urandom);
    vram[10'h0A2] = 8'h5A;
    vram[10'h0BD] = 8'h5A;
    vram[10'h0AC] = 8'h5A;
    rom[12'h2D3]  = 16'hF00F;
    rom[12'hAD3]  = 16'hF00F;
    cprom[8'h22]  = 4'h9;
    cprom[8'h3D]  = 4'h9;
    cprom[8'h2C]  = 4'h9;
    for (int i = 0; i < 8; i++) begin
      lit_n[i] = (i < 4) ? 6'h26 : 6'h25;
      lit_f[i] = (i < 4) ? 6'h25 : 6'h26;
    end

    repeat (3) @(negedge I_CLK);
    chk("reset O_COL", 32'(O_COL), 32'd0);
    chk("reset vram_a", 32'(mem.O_VRAM_A), 32'd0);
    chk("reset rom_a", 32'(mem.O_ROM_A), 32'd0);
    chk("reset cprom_a", 32'(mem.O_CPROM_A), 32'd0);
    chk("reset state", 32'(dut.r_state), 32'(ST_IDLE));
    #5 I_RST_n = 1'b1;
    run_active = 1'b1;

    // Line with known tiles, a blank burst and a bank toggle.
    I_VF = 8'h2B;
    base1 = step_cnt;
    for (int x = 0; x < LP; x++) begin
      if (x == 41) I_BANK = 1'b1;
      pix_step(x, !(x >= 100 && x <= 103));
    end

    // Same data with horizontal flip.
    I_BANK = 1'b0;
    I_HFLIP = 1'b1;
    base2 = step_cnt;
    for (int x = 0; x < LP; x++) pix_step(x, 1'b1);

    chk("lit vram_a x12", 32'(obs_vram[base1 + 12]), 32'h0A2);
    chk("lit rom_a x12", 32'(obs_rom[base1 + 12]), 32'h2D3);
    for (int i = 0; i < 8; i++)
      chk($sformatf("lit col x%0d", 16 + i), 32'(obs_col[base1 + 16 + i]), 32'(lit_n[i]));
    chk("lit bank before", 32'(obs_rom[base1 + 36][11]), 32'd0);
    chk("lit bank after", 32'(obs_rom[base1 + 44][11]), 32'd1);
    chk("lit x99", 32'(obs_col[base1 + 99]), 32'h26);
    for (int i = 0; i < 4; i++)
      chk($sformatf("lit blank x%0d", 100 + i), 32'(obs_col[base1 + 100 + i]), 32'd0);
    chk("lit wrap col", 32'(obs_vram[base1 + 380][4:0]), 32'd0);
    chk("lit flip vram_a", 32'(obs_vram[base2 + 12]), 32'h0BD);
    for (int i = 0; i < 8; i++)
      chk($sformatf("lit flip x%0d", 16 + i), 32'(obs_col[base2 + 16 + i]), 32'(lit_f[i]));

    // Randomized lines.
    for (int ln = 0; ln < 3; ln++) begin
      for (int x = 0; x < LP; x++) begin
        if (x == 360) I_VF = 8'($urandom);
        if ($urandom_range(0, 39) == 0) I_HFLIP = ~I_HFLIP;
        if ($urandom_range(0, 29) == 0) I_BANK = ~I_BANK;
        pix_step(x, $urandom_range(0, 11) != 0);
      end
    end

    // Reset in the middle of a fetch, then keep running.
    for (int ln = 0; ln < 2; ln++) begin
      for (int x = 0; x < LP; x++) begin
        if (x == 360) I_VF = 8'($urandom);
        pix_step(x, $urandom_range(0, 11) != 0);
        if (ln == 0 && x == 204) begin
          chk("state before reset", 32'(dut.r_state), 32'(ST_CODE));
          I_RST_n = 1'b0;
          #1;
          chk("midrst O_COL", 32'(O_COL), 32'd0);
          chk("midrst vram_a", 32'(mem.O_VRAM_A), 32'd0);
          chk("midrst rom_a", 32'(mem.O_ROM_A), 32'd0);
          chk("midrst cprom_a", 32'(mem.O_CPROM_A), 32'd0);
          chk("midrst state", 32'(dut.r_state), 32'(ST_IDLE));
          #5 I_RST_n = 1'b1;
          rel = step_cnt;
        end
      end
    end

    repeat (4) @(negedge I_CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
